monitor_trace_capture: RTL

//  Parametrised multi-channel probe capture engine for the monitor core. Records probe vectors with a cycle

---
 rtl/monitor_trace_capture_if.sv | 42 ++++
 rtl/monitor_trace_capture.sv | 128 ++++++++++++
 2 files changed

// File: rtl/monitor_trace_capture_if.sv
// -----------------------------------------------------------------------------
// monitor_trace_capture_if
//   Bundles the control, probe, readout and status signals of the trace
//   capture engine. Clock and reset are plain ports on the engine itself.
//
//   Handshake: ctrl_start / ctrl_stop / rd_en are single-cycle strobes sampled
//   on the rising clock edge. There is no back-pressure. A read strobe issued
//   while done=1 returns data on rd_data one cycle later. A read strobe at any
//   other time is ignored and rd_data keeps its value.
//
//   master : the software-facing side (register slave or testbench)
//   slave  : the capture engine
// -----------------------------------------------------------------------------
interface monitor_trace_capture_if #(
   parameter int NUM_CH     = 8,
   parameter int TS_WIDTH   = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                         ctrl_start;
   logic                         ctrl_stop;
   logic                         cfg_change;
   logic                         cfg_wrap;
   logic [NUM_CH-1:0]            probe_in;
   logic                         rd_en;
   logic [ADDR_WIDTH-1:0]        rd_addr;
   logic [TS_WIDTH+NUM_CH-1:0]   rd_data;
   logic                         busy;
   logic                         done;
   logic [ADDR_WIDTH:0]          count;
   logic                         wrapped;
   logic [1:0]                   dbg_state;

   modport master (
      output ctrl_start, ctrl_stop, cfg_change, cfg_wrap, probe_in, rd_en, rd_addr,
      input  rd_data, busy, done, count, wrapped, dbg_state
   );

   modport slave (
      input  ctrl_start, ctrl_stop, cfg_change, cfg_wrap, probe_in, rd_en, rd_addr,
      output rd_data, busy, done, count, wrapped, dbg_state
   );
endinterface

// File: rtl/monitor_trace_capture.sv
// -----------------------------------------------------------------------------
// monitor_trace_capture
//   Multi-channel probe capture engine. While running, records {timestamp,
//   probe} into a circular buffer, either every cycle or only when the probe
//   changes. When the buffer fills, capture either stops or overwrites the
//   oldest entry. After capture, entries are read back oldest-first through a
//   registered read port.
//
// Ports
//   ACLK, ARESET    clock, synchronous active-high reset
//   bus (slave)     ctrl_start/ctrl_stop strobes, cfg_change/cfg_wrap (latched
//                   at start), probe_in, rd_en/rd_addr -> rd_data (1-cycle
//                   latency), status busy/done/count/wrapped, dbg_state
// -----------------------------------------------------------------------------
module monitor_trace_capture #(
   parameter int NUM_CH     = 8,
   parameter int TS_WIDTH   = 32,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   monitor_trace_capture_if.slave  bus
);

   localparam int DW = TS_WIDTH + NUM_CH;
   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state_q;
   logic [TS_WIDTH-1:0]     ts_q;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q;
   logic [ADDR_WIDTH:0]     count_q;
   logic                    wrapped_q;
   logic                    first_q;
   logic                    cfg_change_q;
   logic                    cfg_wrap_q;
   logic [NUM_CH-1:0]       prev_q;
   logic                    rd_sel_q;
   logic [DW-1:0]           ram_rd_q;
   logic [DW-1:0]           ram_q [DEPTH];

   logic                    store_d;
   logic [ADDR_WIDTH:0]     count_d;
   logic                    full_stop_d;
   logic                    rd_fire_d;
   logic [ADDR_WIDTH-1:0]   rd_phys_d;
   logic                    rd_in_range_d;

   // ts == 0 forces a store so that a timestamp wrap is always visible in
   // change-only mode.
   assign store_d = (state_q == S_RUN) &&
                    (!cfg_change_q || first_q || (bus.probe_in != prev_q) || (ts_q == '0));

   assign count_d     = (count_q == FULL_CNT) ? count_q : count_q + 1'b1;
   assign full_stop_d = store_d && !cfg_wrap_q && (count_q == FULL_CNT - 1'b1);

   // Once wrapped, the oldest entry sits at the write pointer; the add wraps
   // naturally at DEPTH because DEPTH is a power of two.
   assign rd_fire_d     = (state_q == S_DONE) && bus.rd_en;
   assign rd_phys_d     = (wrapped_q ? wr_ptr_q : '0) + bus.rd_addr;
   assign rd_in_range_d = ({1'b0, bus.rd_addr} < count_q);

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q      <= S_IDLE;
         ts_q         <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         wrapped_q    <= 1'b0;
         first_q      <= 1'b0;
         cfg_change_q <= 1'b0;
         cfg_wrap_q   <= 1'b0;
         prev_q       <= '0;
         rd_sel_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               // start takes priority over any stop in the same cycle
               if (bus.ctrl_start) begin
                  state_q      <= S_RUN;
                  ts_q         <= '0;
                  wr_ptr_q     <= '0;
                  count_q      <= '0;
                  wrapped_q    <= 1'b0;
                  first_q      <= 1'b1;
                  cfg_change_q <= bus.cfg_change;
                  cfg_wrap_q   <= bus.cfg_wrap;
               end
            end
            S_RUN: begin
               ts_q    <= ts_q + TS_WIDTH'(1);
               prev_q  <= bus.probe_in;
               first_q <= 1'b0;
               if (store_d) begin
                  wr_ptr_q <= wr_ptr_q + 1'b1;
                  count_q  <= count_d;
                  if (count_q == FULL_CNT) wrapped_q <= 1'b1;
               end
               if (bus.ctrl_stop || full_stop_d) state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase

         // rd_sel_q masks the RAM output to zero for out-of-range reads
         if (rd_fire_d) rd_sel_q <= rd_in_range_d;
      end
   end

   // Buffer storage kept reset-free so it maps onto block RAM.
   always_ff @(posedge ACLK) begin
      if (store_d) ram_q[wr_ptr_q] <= {ts_q, bus.probe_in};
      if (rd_fire_d) ram_rd_q <= ram_q[rd_phys_d];
   end

   assign bus.rd_data   = rd_sel_q ? ram_rd_q : '0;
   assign bus.busy      = (state_q == S_RUN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.count     = count_q;
   assign bus.wrapped   = wrapped_q;
   assign bus.dbg_state = state_q;

endmodule
